// File: rtl/fetch_stage.sv
// fetch_stage: RV32 instruction fetch with IF/ID register, redirect, stall/flush and halt
module fetch_stage #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0] NOP_INSN = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  input  logic            stall_f,
  input  logic            flush_d,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_d,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d,
  output logic            halted,
  output logic            misaligned
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_n;
  logic [XLEN-1:0] pc_f, pc_n, pcd_n, pc4_n, pc_inc;
  logic [31:0] instr_n;
  logic valid_n, mis_n;
  assign pc_inc = pc_f + XLEN'(4);
  assign imem_addr = pc_f;
  assign halted = state == HALT;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      pc_f <= RESET_PC;
      instr_d <= NOP_INSN;
      pc_d <= '0;
      pc_plus4_d <= '0;
      valid_d <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      state <= state_n;
      pc_f <= pc_n;
      instr_d <= instr_n;
      pc_d <= pcd_n;
      pc_plus4_d <= pc4_n;
      valid_d <= valid_n;
      misaligned <= mis_n;
    end
  end
  always_comb begin
    state_n = state;
    pc_n = pc_f;
    instr_n = instr_d;
    pcd_n = pc_d;
    pc4_n = pc_plus4_d;
    valid_n = 1'b0;
    mis_n = misaligned;
    if (state == RUN) begin
      if (redirect && redirect_pc[1:0] != 2'b00) begin
        mis_n = 1'b1;
        state_n = HALT;
        instr_n = NOP_INSN;
      end else if (redirect) begin
        pc_n = redirect_pc;
        instr_n = NOP_INSN;
      end else if (halt_d && valid_d) begin
        state_n = HALT;
        instr_n = NOP_INSN;
      end else if (stall_f) begin
        instr_n = flush_d ? NOP_INSN : instr_d;
        valid_n = valid_d && !flush_d;
      end else begin
        pc_n = pc_inc;
        instr_n = flush_d ? NOP_INSN : imem_data;
        pcd_n = pc_f;
        pc4_n = pc_inc;
        valid_n = !flush_d;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with directed vectors
module tb_fetch_stage;
  typedef enum int {S_ADDR, S_INSTR, S_PC, S_PC4, S_VALID, S_HALT, S_MIS, S_ADDR2, S_PC2, S_PC42} sig_t;
  typedef struct {int cyc; sig_t sig; logic [31:0] val;} exp_t;
  logic clk = 0, reset = 1, stall_f = 0, flush_d = 0, redirect = 0, halt_d = 0;
  logic [31:0] redirect_pc = 0, imem_addr, imem_data, instr_d, pc_d, pc_plus4_d;
  logic valid_d, halted, misaligned;
  logic [31:0] imem_addr2, imem_data2, instr_d2, pc_d2, pc_plus4_d2;
  logic valid_d2, halted2, misaligned2;
  int cyc = 0, checks = 0, failures = 0;
  exp_t q[$];
  exp_t e;
  logic [31:0] act;
  function automatic logic [31:0] tag(logic [31:0] a);
    return a ^ 32'h5A5A0000;
  endfunction
  assign imem_data = tag(imem_addr);
  assign imem_data2 = tag(imem_addr2);
  fetch_stage dut (.clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall_f(stall_f), .flush_d(flush_d), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt_d(halt_d), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .valid_d(valid_d), .halted(halted), .misaligned(misaligned));
  fetch_stage #(.RESET_PC(32'hFFFFFFFC)) dut2 (.clk(clk), .reset(reset), .imem_addr(imem_addr2),
    .imem_data(imem_data2), .stall_f(1'b0), .flush_d(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
    .halt_d(1'b0), .instr_d(instr_d2), .pc_d(pc_d2), .pc_plus4_d(pc_plus4_d2),
    .valid_d(valid_d2), .halted(halted2), .misaligned(misaligned2));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] get(sig_t s);
    case (s)
      S_ADDR:  return imem_addr;
      S_INSTR: return instr_d;
      S_PC:    return pc_d;
      S_PC4:   return pc_plus4_d;
      S_VALID: return {31'b0, valid_d};
      S_HALT:  return {31'b0, halted};
      S_MIS:   return {31'b0, misaligned};
      S_ADDR2: return imem_addr2;
      S_PC2:   return pc_d2;
      default: return pc_plus4_d2;
    endcase
  endfunction
  always @(negedge clk) begin
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      act = get(e.sig);
      checks++;
      if (e.cyc != cyc || act !== e.val) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%h want=%h", e.sig.name(), e.cyc, act, e.val);
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(sig_t s, logic [31:0] v);
    q.push_back('{cyc, s, v});
  endtask
  task automatic fetched(logic [31:0] pc);
    chk(S_ADDR, pc + 4); chk(S_PC, pc); chk(S_PC4, pc + 4);
    chk(S_INSTR, tag(pc)); chk(S_VALID, 1);
  endtask
  initial begin
    step(); step();
    chk(S_ADDR, 0); chk(S_INSTR, 32'h13); chk(S_PC, 0); chk(S_PC4, 0);
    chk(S_VALID, 0); chk(S_HALT, 0); chk(S_MIS, 0); chk(S_ADDR2, 32'hFFFFFFFC);
    reset = 0;
    step(); fetched(0);
    chk(S_ADDR2, 0); chk(S_PC2, 32'hFFFFFFFC); chk(S_PC42, 0);
    for (int i = 1; i < 4; i++) begin step(); fetched(i * 4); end
    stall_f = 1;
    for (int i = 0; i < 3; i++) begin
      step(); chk(S_ADDR, 32'h10); chk(S_PC, 32'h0C); chk(S_INSTR, tag(32'h0C)); chk(S_VALID, 1);
    end
    stall_f = 0;
    step(); fetched(32'h10);
    redirect = 1; redirect_pc = 32'h200; stall_f = 1;
    step(); chk(S_ADDR, 32'h200); chk(S_VALID, 0); chk(S_INSTR, 32'h13);
    redirect = 0; stall_f = 0;
    step(); fetched(32'h200);
    halt_d = 1; redirect = 1; redirect_pc = 32'h80;
    step(); chk(S_HALT, 0); chk(S_ADDR, 32'h80); chk(S_VALID, 0);
    halt_d = 0; redirect = 0;
    step(); fetched(32'h80);
    halt_d = 1;
    step(); chk(S_HALT, 1); chk(S_VALID, 0); chk(S_ADDR, 32'h84); chk(S_INSTR, 32'h13);
    halt_d = 0; redirect = 1; redirect_pc = 32'h300;
    for (int i = 0; i < 10; i++) begin
      step(); chk(S_ADDR, 32'h84); chk(S_HALT, 1); chk(S_VALID, 0); chk(S_PC, 32'h80); chk(S_MIS, 0);
    end
    reset = 1;
    step(); chk(S_ADDR, 0); chk(S_HALT, 0); chk(S_VALID, 0); chk(S_INSTR, 32'h13);
    reset = 0; redirect = 0;
    step(); fetched(0);
    redirect = 1; redirect_pc = 32'h82;
    step(); chk(S_MIS, 1); chk(S_HALT, 1); chk(S_ADDR, 4); chk(S_VALID, 0);
    redirect = 0;
    step(); chk(S_MIS, 1); chk(S_HALT, 1); chk(S_ADDR, 4);
    reset = 1;
    step(); chk(S_MIS, 0); chk(S_HALT, 0);
    reset = 0;
    step(); fetched(0);
    flush_d = 1;
    step(); chk(S_ADDR, 8); chk(S_VALID, 0); chk(S_INSTR, 32'h13);
    flush_d = 0;
    step(); fetched(8);
    stall_f = 1; flush_d = 1;
    step(); chk(S_ADDR, 32'h0C); chk(S_VALID, 0); chk(S_INSTR, 32'h13);
    stall_f = 0; flush_d = 0;
    step(); fetched(32'h0C);
    step(); step();
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
